// File: rtl/reg_transfer_unit.sv
// Register-transfer core: NREGS x WIDTH registers behind one write port, valid/ready commands.
// state    | meaning
// S_IDLE   | ready; single-cycle ops execute at the accept edge
// S_SWAP_A | R[src] <= R[dst] (R[src] already saved in tmp)
// S_SWAP_B | R[dst] <= tmp, then done
// S_CLR    | R[idx] <= 0 each edge until the last register
module reg_transfer_unit #(
  parameter int WIDTH = 4,
  parameter int NREGS = 4,
  localparam int AW = ($clog2(NREGS) < 1) ? 1 : $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic [AW-1:0]          cmd_dst,
  input  logic [AW-1:0]          cmd_src,
  input  logic [WIDTH-1:0]       cmd_imm,
  output logic                   done,
  output logic                   err,
  output logic                   carry,
  output logic                   zero,
  input  logic [AW-1:0]          rd_addr,
  output logic [WIDTH-1:0]       rd_data,
  output logic [NREGS*WIDTH-1:0] regs_flat
);

  typedef enum logic [1:0] {S_IDLE, S_SWAP_A, S_SWAP_B, S_CLR} state_t;

  localparam logic [2:0] OP_NOP = 3'd0, OP_LDI = 3'd1, OP_INC = 3'd2, OP_DEC = 3'd3,
                         OP_MOV = 3'd4, OP_SWAP = 3'd5, OP_CLRALL = 3'd6, OP_ADD = 3'd7;
  // One extra bit so the range compare is never constant for power-of-2 NREGS
  localparam logic [AW:0]   N_LIM = (AW+1)'(NREGS);
  localparam logic [AW-1:0] LAST  = AW'(NREGS - 1);

  logic [WIDTH-1:0] regs [NREGS];
  state_t           state, state_nxt;
  logic [WIDTH-1:0] tmp, tmp_nxt;
  logic [AW-1:0]    idx, idx_nxt, sw_dst, sw_dst_nxt, sw_src, sw_src_nxt;
  logic             carry_nxt, zero_nxt, done_nxt, err_nxt;
  logic             we;
  logic [AW-1:0]    wa;
  logic [WIDTH-1:0] wd;
  logic             dst_ok, src_ok, rd_ok, uses_dst, uses_src;
  logic [WIDTH-1:0] r_dst, r_src;
  logic [WIDTH:0]   sum;

  assign dst_ok   = {1'b0, cmd_dst} < N_LIM;
  assign src_ok   = {1'b0, cmd_src} < N_LIM;
  assign rd_ok    = {1'b0, rd_addr} < N_LIM;
  assign uses_dst = cmd_op inside {OP_LDI, OP_INC, OP_DEC, OP_MOV, OP_SWAP, OP_ADD};
  assign uses_src = cmd_op inside {OP_MOV, OP_SWAP, OP_ADD};
  assign r_dst    = dst_ok ? regs[cmd_dst] : '0;
  assign r_src    = src_ok ? regs[cmd_src] : '0;
  assign sum      = {1'b0, r_dst} + {1'b0, r_src};

  assign cmd_ready = (state == S_IDLE);
  assign rd_data   = rd_ok ? regs[rd_addr] : '0;

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NREGS; i++) regs_flat[i*WIDTH +: WIDTH] = regs[i];
  end

  always_comb begin
    state_nxt  = state;
    tmp_nxt    = tmp;
    idx_nxt    = idx;
    sw_dst_nxt = sw_dst;
    sw_src_nxt = sw_src;
    carry_nxt  = carry;
    zero_nxt   = zero;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    we         = 1'b0;
    wa         = cmd_dst;
    wd         = cmd_imm;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          if ((uses_dst && !dst_ok) || (uses_src && !src_ok)) begin
            err_nxt = 1'b1;
          end else begin
            case (cmd_op)
              OP_NOP: done_nxt = 1'b1;
              OP_LDI: begin
                we = 1'b1;
                wd = cmd_imm;
                zero_nxt = (wd == '0);
                done_nxt = 1'b1;
              end
              OP_INC: begin
                we = 1'b1;
                wd = r_dst + WIDTH'(1);
                carry_nxt = &r_dst;
                zero_nxt = (wd == '0);
                done_nxt = 1'b1;
              end
              OP_DEC: begin
                we = 1'b1;
                wd = r_dst - WIDTH'(1);
                carry_nxt = (r_dst == '0);
                zero_nxt = (wd == '0);
                done_nxt = 1'b1;
              end
              OP_MOV: begin
                we = 1'b1;
                wd = r_src;
                zero_nxt = (wd == '0);
                done_nxt = 1'b1;
              end
              OP_ADD: begin
                we = 1'b1;
                wd = sum[WIDTH-1:0];
                carry_nxt = sum[WIDTH];
                zero_nxt = (wd == '0);
                done_nxt = 1'b1;
              end
              OP_SWAP: begin
                tmp_nxt    = r_src;
                sw_dst_nxt = cmd_dst;
                sw_src_nxt = cmd_src;
                state_nxt  = S_SWAP_A;
              end
              default: begin
                idx_nxt   = '0;
                state_nxt = S_CLR;
              end
            endcase
          end
        end
      end
      S_SWAP_A: begin
        we = 1'b1;
        wa = sw_src;
        wd = regs[sw_dst];
        state_nxt = S_SWAP_B;
      end
      S_SWAP_B: begin
        we = 1'b1;
        wa = sw_dst;
        wd = tmp;
        state_nxt = S_IDLE;
        done_nxt = 1'b1;
      end
      S_CLR: begin
        we = 1'b1;
        wa = idx;
        wd = '0;
        idx_nxt = idx + AW'(1);
        if (idx == LAST) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
          zero_nxt  = 1'b1;
          carry_nxt = 1'b0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      state  <= S_IDLE;
      tmp    <= '0;
      idx    <= '0;
      sw_dst <= '0;
      sw_src <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (we) regs[wa] <= wd;
      state  <= state_nxt;
      tmp    <= tmp_nxt;
      idx    <= idx_nxt;
      sw_dst <= sw_dst_nxt;
      sw_src <= sw_src_nxt;
      carry  <= carry_nxt;
      zero   <= zero_nxt;
      done   <= done_nxt;
      err    <= err_nxt;
    end
  end

endmodule

// File: tb/tb_reg_transfer_unit.sv
// Directed bench: a 4-register and a 3-register instance share the command bus,
// each with its own cmd_valid.
module tb_reg_transfer_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v4 = 1'b0, v3 = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [1:0]  dst = 2'd0, src = 2'd0, rd_addr = 2'd0;
  logic [3:0]  imm = 4'd0;

  logic        rdy4, done4, err4, carry4, zero4;
  logic [3:0]  rdat4;
  logic [15:0] flat4;
  logic        rdy3, done3, err3, carry3, zero3;
  logic [3:0]  rdat3;
  logic [11:0] flat3;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reg_transfer_unit #(.WIDTH(4), .NREGS(4)) dut4 (
    .clk(clk), .rst(rst), .cmd_valid(v4), .cmd_ready(rdy4), .cmd_op(op),
    .cmd_dst(dst), .cmd_src(src), .cmd_imm(imm), .done(done4), .err(err4),
    .carry(carry4), .zero(zero4), .rd_addr(rd_addr), .rd_data(rdat4), .regs_flat(flat4)
  );

  reg_transfer_unit #(.WIDTH(4), .NREGS(3)) dut3 (
    .clk(clk), .rst(rst), .cmd_valid(v3), .cmd_ready(rdy3), .cmd_op(op),
    .cmd_dst(dst), .cmd_src(src), .cmd_imm(imm), .done(done3), .err(err3),
    .carry(carry3), .zero(zero3), .rd_addr(rd_addr), .rd_data(rdat3), .regs_flat(flat3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one command from a negedge, return at the negedge after its accept edge
  task automatic issue(input bit to3, input logic [2:0] o, input logic [1:0] d,
                       input logic [1:0] s, input logic [3:0] im);
    @(negedge clk);
    op = o; dst = d; src = s; imm = im;
    if (to3) v3 = 1'b1; else v4 = 1'b1;
    @(negedge clk);
    v3 = 1'b0; v4 = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a);
    rd_addr = a;
    #1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_flat", 32'(flat4), 32'h0);
    chk("rst_done", 32'(done4), 32'h0);
    chk("rst_err", 32'(err4), 32'h0);
    chk("rst_carry", 32'(carry4), 32'h0);
    chk("rst_zero", 32'(zero4), 32'h0);
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(rdy4), 32'h1);

    // back-to-back LDI
    op = 3'd1; dst = 2'd0; imm = 4'h9; v4 = 1'b1;
    @(negedge clk);
    chk("ldi0_done", 32'(done4), 32'h1);
    chk("ldi0_ready", 32'(rdy4), 32'h1);
    dst = 2'd1; imm = 4'h3;
    @(negedge clk);
    chk("ldi1_done", 32'(done4), 32'h1);
    chk("ldi_flat", 32'(flat4), 32'h0039);
    v4 = 1'b0;
    @(negedge clk);
    chk("ldi_done_low", 32'(done4), 32'h0);

    // INC wrap / DEC borrow
    issue(0, 3'd1, 2'd2, 2'd0, 4'hF);
    issue(0, 3'd2, 2'd2, 2'd0, 4'h0);
    rd(2'd2);
    chk("inc_val", 32'(rdat4), 32'h0);
    chk("inc_carry", 32'(carry4), 32'h1);
    chk("inc_zero", 32'(zero4), 32'h1);
    chk("inc_done", 32'(done4), 32'h1);
    issue(0, 3'd3, 2'd2, 2'd0, 4'h0);
    chk("dec_val", 32'(rdat4), 32'hF);
    chk("dec_carry", 32'(carry4), 32'h1);
    chk("dec_zero", 32'(zero4), 32'h0);

    // NOP keeps everything
    issue(0, 3'd0, 2'd0, 2'd0, 4'h0);
    chk("nop_done", 32'(done4), 32'h1);
    chk("nop_carry", 32'(carry4), 32'h1);
    chk("nop_flat", 32'(flat4), 32'h0F39);

    // SWAP R0<->R1 with an ignored command while busy
    @(negedge clk);
    op = 3'd5; dst = 2'd0; src = 2'd1; v4 = 1'b1;
    @(negedge clk);
    chk("swap_busy_a", 32'(rdy4), 32'h0);
    op = 3'd1; dst = 2'd2; imm = 4'h5;
    @(negedge clk);
    chk("swap_busy_b", 32'(rdy4), 32'h0);
    chk("swap_nodone", 32'(done4), 32'h0);
    v4 = 1'b0;
    @(negedge clk);
    chk("swap_done", 32'(done4), 32'h1);
    chk("swap_ready", 32'(rdy4), 32'h1);
    chk("swap_flat", 32'(flat4), 32'h0F93);
    chk("swap_carry", 32'(carry4), 32'h1);
    @(negedge clk);
    chk("swap_done_low", 32'(done4), 32'h0);

    // ADD with carry, MOV keeps carry, ADD without carry
    issue(0, 3'd2, 2'd3, 2'd0, 4'h0);
    chk("inc3_carry", 32'(carry4), 32'h0);
    issue(0, 3'd1, 2'd0, 2'd0, 4'h9);
    issue(0, 3'd7, 2'd0, 2'd1, 4'h0);
    rd(2'd0);
    chk("add_val", 32'(rdat4), 32'h2);
    chk("add_carry", 32'(carry4), 32'h1);
    chk("add_zero", 32'(zero4), 32'h0);
    issue(0, 3'd4, 2'd3, 2'd0, 4'h0);
    rd(2'd3);
    chk("mov_val", 32'(rdat4), 32'h2);
    chk("mov_carry", 32'(carry4), 32'h1);
    chk("mov_flat", 32'(flat4), 32'h2F92);
    issue(0, 3'd7, 2'd3, 2'd1, 4'h0);
    chk("add2_val", 32'(rdat4), 32'hB);
    chk("add2_carry", 32'(carry4), 32'h0);

    // NREGS=3: range errors and CLRALL
    issue(1, 3'd1, 2'd0, 2'd0, 4'h1);
    issue(1, 3'd1, 2'd1, 2'd0, 4'h2);
    issue(1, 3'd1, 2'd2, 2'd0, 4'h3);
    chk("n3_flat", 32'(flat3), 32'h321);
    issue(1, 3'd1, 2'd3, 2'd0, 4'h7);
    chk("n3_err", 32'(err3), 32'h1);
    chk("n3_err_nodone", 32'(done3), 32'h0);
    chk("n3_err_flat", 32'(flat3), 32'h321);
    @(negedge clk);
    chk("n3_err_low", 32'(err3), 32'h0);
    issue(1, 3'd4, 2'd0, 2'd3, 4'h0);
    chk("n3_src_err", 32'(err3), 32'h1);
    chk("n3_src_flat", 32'(flat3), 32'h321);
    rd(2'd3);
    chk("n3_rd_oob", 32'(rdat3), 32'h0);
    chk("n3_zero_pre", 32'(zero3), 32'h0);
    issue(1, 3'd6, 2'd3, 2'd3, 4'h0);
    chk("clr_busy", 32'(rdy3), 32'h0);
    chk("clr_nodone0", 32'(done3), 32'h0);
    @(negedge clk);
    chk("clr_r0", 32'(flat3), 32'h320);
    chk("clr_nodone1", 32'(done3), 32'h0);
    @(negedge clk);
    chk("clr_nodone2", 32'(done3), 32'h0);
    @(negedge clk);
    chk("clr_done", 32'(done3), 32'h1);
    chk("clr_flat", 32'(flat3), 32'h000);
    chk("clr_zero", 32'(zero3), 32'h1);
    chk("clr_carry", 32'(carry3), 32'h0);
    chk("clr_ready", 32'(rdy3), 32'h1);

    // reset during SWAP_A
    @(negedge clk);
    op = 3'd5; dst = 2'd0; src = 2'd1; v4 = 1'b1;
    @(negedge clk);
    v4 = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_flat", 32'(flat4), 32'h0);
    chk("mid_rst_ready", 32'(rdy4), 32'h1);
    @(negedge clk);
    chk("mid_rst_nodone", 32'(done4), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_nodone", 32'(done4), 32'h0);
    chk("post_rst_flat", 32'(flat4), 32'h0);
    issue(0, 3'd1, 2'd1, 2'd0, 4'h7);
    rd(2'd1);
    chk("resume_done", 32'(done4), 32'h1);
    chk("resume_val", 32'(rdat4), 32'h7);
    chk("resume_flat", 32'(flat4), 32'h0070);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
